// File: rtl/bp_pkg.sv
// bp_pkg: shared types and counter helpers for the branch predictor.
// Contents: btb_entry_t (valid, jump, tag, target), counter constants
// cnt_weak_t/cnt_weak_nt (weakly taken / weakly not taken) and saturating
// sat_inc/sat_dec. Counters are handled at CNT_MAX_W bits and narrowed by users.
package bp_pkg;
    localparam int BP_W = 32;
    localparam int CNT_MAX_W = 16;
    typedef logic [CNT_MAX_W-1:0] cnt_t;
    typedef struct packed {
        logic            valid;
        logic            jump;
        logic [BP_W-1:0] tag;
        logic [BP_W-1:0] target;
    } btb_entry_t;
    function automatic cnt_t cnt_weak_t(input int w);
        return cnt_t'(1) << (w - 1);
    endfunction
    function automatic cnt_t cnt_weak_nt(input int w);
        return cnt_weak_t(w) - cnt_t'(1);
    endfunction
    // all-ones for width w is (2^(w-1) << 1) - 1
    function automatic cnt_t sat_inc(input cnt_t c, input int w);
        return (c == (cnt_weak_t(w) << 1) - cnt_t'(1)) ? c : c + cnt_t'(1);
    endfunction
    function automatic cnt_t sat_dec(input cnt_t c);
        return (c == '0) ? c : c - cnt_t'(1);
    endfunction
endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: direction counter array with saturating update.
// Ports: clk, rst (async active-low), rd_idx -> rd_taken (counter MSB),
// upd/wr_idx/taken update one counter; alloc loads weakly-taken instead.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int CNT_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output logic                       rd_taken,
    input  logic                       upd,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  logic                       taken,
    input  logic                       alloc
);
    logic [CNT_WIDTH-1:0] cnt [ENTRIES];
    logic [CNT_WIDTH-1:0] nxt;

    assign rd_taken = cnt[rd_idx][CNT_WIDTH-1];

    always_comb
        nxt = alloc ? CNT_WIDTH'(cnt_weak_t(CNT_WIDTH))
            : taken ? CNT_WIDTH'(sat_inc(cnt_t'(cnt[wr_idx]), CNT_WIDTH))
            : CNT_WIDTH'(sat_dec(cnt_t'(cnt[wr_idx])));

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_WIDTH'(cnt_weak_nt(CNT_WIDTH));
        else if (upd)
            cnt[wr_idx] <= nxt;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus saturating direction counters.
// Fetch: PCF -> PredTakenF, PredTargetF (combinational, no bypass of same-cycle update).
// Execute: UpdateE, IsJumpE, PCE, TakenE, TargetE, PredTakenE, PredTargetE
//   -> MispredictE, RecoverPCE, MispredCount (saturating).
// clk rising edge; rst asynchronous active-low.
// Optional macro BP_GSHARE_EN: counter index hashed with a non-speculative GHR.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CNT_WIDTH  = 2,
    parameter int GHR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PCF,
    output logic                  PredTakenF,
    output logic [DATA_WIDTH-1:0] PredTargetF,
    input  logic                  UpdateE,
    input  logic                  IsJumpE,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic                  TakenE,
    input  logic [DATA_WIDTH-1:0] TargetE,
    input  logic                  PredTakenE,
    input  logic [DATA_WIDTH-1:0] PredTargetE,
    output logic                  MispredictE,
    output logic [DATA_WIDTH-1:0] RecoverPCE,
    output logic [DATA_WIDTH-1:0] MispredCount
);
    localparam int IDX = $clog2(ENTRIES);

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || CNT_WIDTH < 1 ||
        CNT_WIDTH > CNT_MAX_W || GHR_WIDTH < 1 || DATA_WIDTH > BP_W || DATA_WIDTH < IDX + 3) begin : g_bad_cfg
        $error("branch_predictor: unsupported parameter set");
    end

    btb_entry_t     btb [ENTRIES];
    btb_entry_t     ent_f;
    logic [IDX-1:0] idx_f, idx_e, cidx_f, cidx_e;
    logic           hit_f, cnt_taken, alloc;

    assign idx_f = PCF[IDX+1:2];
    assign idx_e = PCE[IDX+1:2];
    assign ent_f = btb[idx_f];
    assign hit_f = ent_f.valid && ent_f.tag == BP_W'(PCF >> (IDX + 2));

    assign PredTakenF  = hit_f & (ent_f.jump | cnt_taken);
    assign PredTargetF = PredTakenF ? DATA_WIDTH'(ent_f.target) : PCF + DATA_WIDTH'(4);

    assign MispredictE = UpdateE & ((TakenE != PredTakenE) | (TakenE & (TargetE != PredTargetE)));
    assign RecoverPCE  = TakenE ? TargetE : PCE + DATA_WIDTH'(4);

`ifdef BP_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr;
    // history is shifted at resolve, so lookup and update both hash with the committed GHR
    assign cidx_f = idx_f ^ IDX'(ghr);
    assign cidx_e = idx_e ^ IDX'(ghr);
    assign alloc  = 1'b0;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            ghr <= '0;
        else if (UpdateE && !IsJumpE)
            ghr <= GHR_WIDTH'({ghr, TakenE});
`else
    logic hit_e;
    assign hit_e  = btb[idx_e].valid && btb[idx_e].tag == BP_W'(PCE >> (IDX + 2));
    assign cidx_f = idx_f;
    assign cidx_e = idx_e;
    assign alloc  = ~hit_e & TakenE;
`endif

    bp_counter_table #(.ENTRIES(ENTRIES), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (cidx_f),
        .rd_taken (cnt_taken),
        .upd      (UpdateE),
        .wr_idx   (cidx_e),
        .taken    (TakenE),
        .alloc    (alloc)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
            MispredCount <= '0;
        end else begin
            if (UpdateE && TakenE)
                btb[idx_e] <= '{valid: 1'b1, jump: IsJumpE, tag: BP_W'(PCE >> (IDX + 2)), target: BP_W'(TargetE)};
            if (MispredictE && !(&MispredCount))
                MispredCount <= MispredCount + DATA_WIDTH'(1);
        end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PCF = 32'h100;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdateE = 1'b0, IsJumpE = 1'b0, TakenE = 1'b0, PredTakenE = 1'b0;
    logic [31:0] PCE = '0, TargetE = '0, PredTargetE = '0;
    logic        MispredictE;
    logic [31:0] RecoverPCE, MispredCount;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .PCF          (PCF),
        .PredTakenF   (PredTakenF),
        .PredTargetF  (PredTargetF),
        .UpdateE      (UpdateE),
        .IsJumpE      (IsJumpE),
        .PCE          (PCE),
        .TakenE       (TakenE),
        .TargetE      (TargetE),
        .PredTakenE   (PredTakenE),
        .PredTargetE  (PredTargetE),
        .MispredictE  (MispredictE),
        .RecoverPCE   (RecoverPCE),
        .MispredCount (MispredCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        PCF = pc;
        #1;
        check({tag, ".taken"}, 32'(PredTakenF), 32'(pt));
        check({tag, ".target"}, PredTargetF, tgt);
    endtask

    // correctly predicted resolve: piped prediction equals the outcome
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic jmp);
        UpdateE = 1'b1; PCE = pc; TakenE = tk; TargetE = tgt; IsJumpE = jmp;
        PredTakenE = tk; PredTargetE = tgt;
        @(posedge clk); #1;
        UpdateE = 1'b0;
    endtask

    task automatic exec(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
        UpdateE = 1'b1; PCE = pc; TakenE = tk; TargetE = tgt; IsJumpE = 1'b0;
        PredTakenE = ptk; PredTargetE = ptgt;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        look("rst", 32'h100, 1'b0, 32'h104);
        check("rst.count", MispredCount, 32'd0);
        check("rst.mispred", 32'(MispredictE), 32'd0);
        exec(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        look("nobypass", 32'h100, 1'b0, 32'h104);
        check("alloc.mispred", 32'(MispredictE), 32'd0);
        @(posedge clk); #1;
        UpdateE = 1'b0;
        look("alloc", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("dec0", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look("sat0", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look("inc2", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("sat3", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("dec1", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look("hit", 32'h100, 1'b1, 32'h80);
        look("alias", 32'h140, 1'b0, 32'h144);
        upd(32'h200, 1'b1, 32'h40, 1'b1);
        upd(32'h300, 1'b0, 32'h0, 1'b0);
        upd(32'h300, 1'b0, 32'h0, 1'b0);
        look("jump", 32'h200, 1'b1, 32'h40);
        look("evict", 32'h100, 1'b0, 32'h104);
        look("nt_noalloc", 32'h300, 1'b0, 32'h304);
        check("count.pre", MispredCount, 32'd0);
        exec(32'h104, 1'b1, 32'h300, 1'b0, 32'h108);
        #1;
        check("mis_t.flag", 32'(MispredictE), 32'd1);
        check("mis_t.recover", RecoverPCE, 32'h300);
        @(posedge clk); #1;
        check("mis_t.count", MispredCount, 32'd1);
        exec(32'h108, 1'b0, 32'h0, 1'b1, 32'h500);
        #1;
        check("mis_nt.flag", 32'(MispredictE), 32'd1);
        check("mis_nt.recover", RecoverPCE, 32'h10C);
        @(posedge clk); #1;
        check("mis_nt.count", MispredCount, 32'd2);
        exec(32'h10C, 1'b1, 32'h600, 1'b1, 32'h604);
        #1;
        check("mis_tgt.flag", 32'(MispredictE), 32'd1);
        check("mis_tgt.recover", RecoverPCE, 32'h600);
        @(posedge clk); #1;
        check("mis_tgt.count", MispredCount, 32'd3);
        exec(32'h110, 1'b1, 32'h600, 1'b1, 32'h600);
        #1;
        check("ok.flag", 32'(MispredictE), 32'd0);
        UpdateE = 1'b0; PredTakenE = 1'b0;
        #1;
        check("idle.flag", 32'(MispredictE), 32'd0);
        @(posedge clk); #1;
        check("idle.count", MispredCount, 32'd3);
        look("prerst", 32'h104, 1'b1, 32'h300);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("arst.count", MispredCount, 32'd0);
        look("arst.e1", 32'h104, 1'b0, 32'h108);
        look("arst.jump", 32'h200, 1'b0, 32'h204);
        @(posedge clk); #1;
        rst = 1'b1;
        look("post.rst", 32'h10C, 1'b0, 32'h110);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
